// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: shares the single ROB writeback/wakeup port between the
// ALU and the load unit. Each requester has a small circular FIFO; one
// buffered head per cycle is granted (ALU first, with a starvation counter
// forcing load progress) and emitted as a registered one-cycle pulse.
// A retire-time flush discards everything buffered.
// Optional feature macro: ROB_WB_ARB_BYPASS_EN lets a request arriving at an
// empty buffer compete for the grant in the same cycle (1-cycle latency).
module rob_wb_arbiter #(
  parameter int ALU_BUF_DEPTH  = 2,
  parameter int LD_BUF_DEPTH   = 2,
  parameter int STARVE_LIMIT   = 3,
  parameter int ROB_ID_WIDTH   = 4,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_aL,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ROB_ID_WIDTH-1:0]   alu_rob_id,
  input  logic [REG_DATA_WIDTH-1:0] alu_reg_data,
  input  logic                      alu_npc_valid,
  input  logic                      alu_npc_mispred,
  input  logic [ADDR_WIDTH-1:0]     alu_npc,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ROB_ID_WIDTH-1:0]   ld_rob_id,
  input  logic [REG_DATA_WIDTH-1:0] ld_reg_data,
  input  logic                      flush,
  output logic                      wb_valid,
  output logic                      wb_src,
  output logic [ROB_ID_WIDTH-1:0]   wb_rob_id,
  output logic [REG_DATA_WIDTH-1:0] wb_reg_data,
  output logic                      wb_npc_valid,
  output logic                      wb_npc_mispred,
  output logic [ADDR_WIDTH-1:0]     wb_npc
);

  localparam int AE_W = ROB_ID_WIDTH + REG_DATA_WIDTH + 2 + ADDR_WIDTH;
  localparam int LE_W = ROB_ID_WIDTH + REG_DATA_WIDTH;
  localparam int AP_W = (ALU_BUF_DEPTH > 1) ? $clog2(ALU_BUF_DEPTH) : 1;
  localparam int LP_W = (LD_BUF_DEPTH > 1) ? $clog2(LD_BUF_DEPTH) : 1;
  localparam int AC_W = $clog2(ALU_BUF_DEPTH + 1);
  localparam int LC_W = $clog2(LD_BUF_DEPTH + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [AE_W-1:0] alu_mem [ALU_BUF_DEPTH];
  logic [LE_W-1:0] ld_mem  [LD_BUF_DEPTH];
  logic [AP_W-1:0] alu_wr_ptr, alu_rd_ptr;
  logic [LP_W-1:0] ld_wr_ptr, ld_rd_ptr;
  logic [AC_W-1:0] alu_cnt;
  logic [LC_W-1:0] ld_cnt;
  logic [SC_W-1:0] starve_cnt;

  logic [AE_W-1:0] alu_in_ent, alu_cand_ent_p0;
  logic [LE_W-1:0] ld_in_ent, ld_cand_ent_p0;
  logic            alu_byp_p0, ld_byp_p0;
  logic            alu_cand_vld_p0, ld_cand_vld_p0;
  logic            grant_alu_p0, grant_ld_p0;
  logic            alu_enq, alu_deq, ld_enq, ld_deq;

  logic [ROB_ID_WIDTH-1:0]   c_alu_rob_id, c_ld_rob_id;
  logic [REG_DATA_WIDTH-1:0] c_alu_data, c_ld_data;
  logic                      c_alu_nv, c_alu_nm;
  logic [ADDR_WIDTH-1:0]     c_alu_npc;

  function automatic logic [AP_W-1:0] alu_ptr_inc(input logic [AP_W-1:0] p);
    return (p == AP_W'(ALU_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [LP_W-1:0] ld_ptr_inc(input logic [LP_W-1:0] p);
    return (p == LP_W'(LD_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: buffer heads, handshake and grant
  assign alu_ready  = (alu_cnt != AC_W'(ALU_BUF_DEPTH)) && !flush;
  assign ld_ready   = (ld_cnt != LC_W'(LD_BUF_DEPTH)) && !flush;
  assign alu_in_ent = {alu_rob_id, alu_reg_data, alu_npc_valid, alu_npc_mispred, alu_npc};
  assign ld_in_ent  = {ld_rob_id, ld_reg_data};

`ifdef ROB_WB_ARB_BYPASS_EN
  // ready already folds in !flush, so bypass is off during a flush
  assign alu_byp_p0 = (alu_cnt == '0) && alu_valid && alu_ready;
  assign ld_byp_p0  = (ld_cnt == '0) && ld_valid && ld_ready;
`else
  assign alu_byp_p0 = 1'b0;
  assign ld_byp_p0  = 1'b0;
`endif

  assign alu_cand_vld_p0 = (alu_cnt != '0) || alu_byp_p0;
  assign ld_cand_vld_p0  = (ld_cnt != '0) || ld_byp_p0;
  assign alu_cand_ent_p0 = (alu_cnt != '0) ? alu_mem[alu_rd_ptr] : alu_in_ent;
  assign ld_cand_ent_p0  = (ld_cnt != '0) ? ld_mem[ld_rd_ptr] : ld_in_ent;
  assign {c_alu_rob_id, c_alu_data, c_alu_nv, c_alu_nm, c_alu_npc} = alu_cand_ent_p0;
  assign {c_ld_rob_id, c_ld_data} = ld_cand_ent_p0;

  // Fixed ALU priority unless the load has waited STARVE_LIMIT ALU wins
  always_comb begin
    grant_alu_p0 = 1'b0;
    grant_ld_p0  = 1'b0;
    if (!flush) begin
      if (alu_cand_vld_p0 && ld_cand_vld_p0) begin
        if (starve_cnt == SC_W'(STARVE_LIMIT)) grant_ld_p0 = 1'b1;
        else                                   grant_alu_p0 = 1'b1;
      end else if (alu_cand_vld_p0) begin
        grant_alu_p0 = 1'b1;
      end else if (ld_cand_vld_p0) begin
        grant_ld_p0 = 1'b1;
      end
    end
  end

  // A bypassed grant consumes the input directly and never touches the FIFO
  assign alu_deq = grant_alu_p0 && (alu_cnt != '0);
  assign ld_deq  = grant_ld_p0 && (ld_cnt != '0);
  assign alu_enq = alu_valid && alu_ready && !(grant_alu_p0 && alu_byp_p0);
  assign ld_enq  = ld_valid && ld_ready && !(grant_ld_p0 && ld_byp_p0);

  // FIFO payload storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (alu_enq) alu_mem[alu_wr_ptr] <= alu_in_ent;
    if (ld_enq)  ld_mem[ld_wr_ptr]   <= ld_in_ent;
  end

  // FIFO pointers and occupancy; reset or flush empties both buffers
  always_ff @(posedge clk) begin
    if (!rst_aL || flush) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
      ld_wr_ptr  <= '0;
      ld_rd_ptr  <= '0;
      ld_cnt     <= '0;
    end else begin
      if (alu_enq) alu_wr_ptr <= alu_ptr_inc(alu_wr_ptr);
      if (alu_deq) alu_rd_ptr <= alu_ptr_inc(alu_rd_ptr);
      if (alu_enq && !alu_deq)      alu_cnt <= alu_cnt + 1'b1;
      else if (!alu_enq && alu_deq) alu_cnt <= alu_cnt - 1'b1;
      if (ld_enq) ld_wr_ptr <= ld_ptr_inc(ld_wr_ptr);
      if (ld_deq) ld_rd_ptr <= ld_ptr_inc(ld_rd_ptr);
      if (ld_enq && !ld_deq)      ld_cnt <= ld_cnt + 1'b1;
      else if (!ld_enq && ld_deq) ld_cnt <= ld_cnt - 1'b1;
    end
  end

  // Starvation counter: counts ALU wins while a load is waiting
  always_ff @(posedge clk) begin
    if (!rst_aL || flush) begin
      starve_cnt <= '0;
    end else if (grant_ld_p0 || !ld_cand_vld_p0) begin
      starve_cnt <= '0;
    end else if (grant_alu_p0 && alu_cand_vld_p0 &&
                 (starve_cnt != SC_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stage p1: registered writeback pulse; data holds when no grant
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      wb_valid       <= 1'b0;
      wb_src         <= 1'b0;
      wb_rob_id      <= '0;
      wb_reg_data    <= '0;
      wb_npc_valid   <= 1'b0;
      wb_npc_mispred <= 1'b0;
      wb_npc         <= '0;
    end else begin
      wb_valid <= grant_alu_p0 || grant_ld_p0;
      if (grant_alu_p0) begin
        wb_src         <= 1'b0;
        wb_rob_id      <= c_alu_rob_id;
        wb_reg_data    <= c_alu_data;
        wb_npc_valid   <= c_alu_nv;
        wb_npc_mispred <= c_alu_nm;
        wb_npc         <= c_alu_npc;
      end else if (grant_ld_p0) begin
        wb_src         <= 1'b1;
        wb_rob_id      <= c_ld_rob_id;
        wb_reg_data    <= c_ld_data;
        wb_npc_valid   <= 1'b0;
        wb_npc_mispred <= 1'b0;
        wb_npc         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_rob_wb_arbiter;

`ifdef ROB_WB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rob_id;
  logic [31:0] alu_reg_data;
  logic        alu_npc_valid, alu_npc_mispred;
  logic [31:0] alu_npc;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_rob_id;
  logic [31:0] ld_reg_data;
  logic        flush;
  logic        wb_valid, wb_src;
  logic [3:0]  wb_rob_id;
  logic [31:0] wb_reg_data;
  logic        wb_npc_valid, wb_npc_mispred;
  logic [31:0] wb_npc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic        nv;
    logic        nm;
    logic [31:0] npc;
    int          at;
  } exp_t;

  exp_t alu_q[$];
  exp_t ld_q[$];
  bit   src_q[$];

  rob_wb_arbiter dut (
    .clk(clk), .rst_aL(rst_aL),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
    .alu_reg_data(alu_reg_data), .alu_npc_valid(alu_npc_valid),
    .alu_npc_mispred(alu_npc_mispred), .alu_npc(alu_npc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rob_id(ld_rob_id),
    .ld_reg_data(ld_reg_data), .flush(flush),
    .wb_valid(wb_valid), .wb_src(wb_src), .wb_rob_id(wb_rob_id),
    .wb_reg_data(wb_reg_data), .wb_npc_valid(wb_npc_valid),
    .wb_npc_mispred(wb_npc_mispred), .wb_npc(wb_npc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  // Monitor: every writeback pulse must match the next expected entry
  always @(negedge clk) begin : mon
    exp_t e;
    bit   s;
    bit   have;
    if (wb_valid === 1'b1) begin
      if (src_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got rob_id %0h src %0d want no writeback", wb_rob_id, wb_src);
      end else begin
        s = src_q.pop_front();
        chk("wb_src", {63'd0, wb_src}, {63'd0, s});
        have = 1'b0;
        if (wb_src == 1'b0 && alu_q.size() > 0) begin
          e = alu_q.pop_front();
          have = 1'b1;
        end else if (wb_src == 1'b1 && ld_q.size() > 0) begin
          e = ld_q.pop_front();
          have = 1'b1;
        end
        if (!have) begin
          total++;
          bad++;
          $display("FAIL wb_no_expected: got src %0d rob_id %0h want none pending", wb_src, wb_rob_id);
        end else begin
          chk("wb_rob_id", {60'd0, wb_rob_id}, {60'd0, e.id});
          chk("wb_reg_data", {32'd0, wb_reg_data}, {32'd0, e.data});
          chk("wb_npc_valid", {63'd0, wb_npc_valid}, {63'd0, e.nv});
          chk("wb_npc_mispred", {63'd0, wb_npc_mispred}, {63'd0, e.nm});
          chk("wb_npc", {32'd0, wb_npc}, {32'd0, e.npc});
          if (e.at >= 0) chk("wb_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic put_alu(input logic [3:0] id, input logic [31:0] d,
                         input logic nv, input logic nm, input logic [31:0] npc);
    alu_valid       = 1'b1;
    alu_rob_id      = id;
    alu_reg_data    = d;
    alu_npc_valid   = nv;
    alu_npc_mispred = nm;
    alu_npc         = npc;
  endtask

  task automatic put_ld(input logic [3:0] id, input logic [31:0] d);
    ld_valid    = 1'b1;
    ld_rob_id   = id;
    ld_reg_data = d;
  endtask

  task automatic exp_alu(input logic [3:0] id, input logic [31:0] d, input logic nv,
                         input logic nm, input logic [31:0] npc, input int at);
    alu_q.push_back(exp_t'{id, d, nv, nm, npc, at});
  endtask

  task automatic exp_ld(input logic [3:0] id, input logic [31:0] d, input int at);
    ld_q.push_back(exp_t'{id, d, 1'b0, 1'b0, 32'd0, at});
  endtask

  task automatic rdy(input string n, input logic ea, input logic el);
    #1;
    chk({n, "_alu_ready"}, {63'd0, alu_ready}, {63'd0, ea});
    chk({n, "_ld_ready"}, {63'd0, ld_ready}, {63'd0, el});
  endtask

  task automatic chk_wb_zero(input string n);
    chk({n, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    chk({n, "_wb_src"}, {63'd0, wb_src}, 64'd0);
    chk({n, "_wb_rob_id"}, {60'd0, wb_rob_id}, 64'd0);
    chk({n, "_wb_reg_data"}, {32'd0, wb_reg_data}, 64'd0);
    chk({n, "_wb_npc_valid"}, {63'd0, wb_npc_valid}, 64'd0);
    chk({n, "_wb_npc_mispred"}, {63'd0, wb_npc_mispred}, 64'd0);
    chk({n, "_wb_npc"}, {32'd0, wb_npc}, 64'd0);
  endtask

  task automatic chk_drained(input string n);
    chk({n, "_alu_q_left"}, 64'(alu_q.size()), 64'd0);
    chk({n, "_ld_q_left"}, 64'(ld_q.size()), 64'd0);
    chk({n, "_src_q_left"}, 64'(src_q.size()), 64'd0);
  endtask

  initial begin
    bit am [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    bit lm [12] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int c;

    rst_aL = 1'b0;
    idle();
    put_alu(4'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    put_ld(4'd0, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_aL = 1'b1;

    // Reset state
    chk_wb_zero("reset");
    rdy("reset", 1'b1, 1'b1);
    tick();

    // Single ALU writeback with full branch info
    c = cyc;
    put_alu(4'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h100);
    exp_alu(4'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h100, c + LAT);
    src_q.push_back(1'b0);
    rdy("single", 1'b1, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    chk_drained("single");

    // Back-to-back ALU requests: one writeback per cycle, in order
    c = cyc;
    for (int i = 1; i <= 3; i++) begin
      put_alu(4'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 32'h40 * 32'(i));
      exp_alu(4'(i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 32'h40 * 32'(i), c + i - 1 + LAT);
      src_q.push_back(1'b0);
      rdy("b2b", 1'b1, 1'b1);
      tick();
    end
    idle();
    repeat (4) tick();
    chk_drained("b2b");

`ifndef ROB_WB_ARB_BYPASS_EN
    // Both requesters every cycle: A,A,A,L pattern, full buffers refuse input
    for (int r = 0; r < 3; r++) begin
      src_q.push_back(1'b0);
      src_q.push_back(1'b0);
      src_q.push_back(1'b0);
      src_q.push_back(1'b1);
    end
    src_q.push_back(1'b0);
    src_q.push_back(1'b1);
    for (int k = 0; k < 12; k++) begin
      put_alu(4'(k), 32'hA000_0000 + 32'(k), (k % 2) == 1, 1'b0, 32'(k * 4));
      put_ld(4'(k), 32'hB000_0000 + 32'(k));
      if (am[k]) exp_alu(4'(k), 32'hA000_0000 + 32'(k), (k % 2) == 1, 1'b0, 32'(k * 4), -1);
      if (lm[k]) exp_ld(4'(k), 32'hB000_0000 + 32'(k), -1);
      rdy($sformatf("starve_k%0d", k), am[k], lm[k]);
      tick();
    end
    idle();
    repeat (6) tick();
    chk_drained("starve");

    // Flush with ALU {2} and LD {6,7} buffered: only the already granted 1 emerges
    c = cyc;
    put_alu(4'd1, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
    put_ld(4'd6, 32'h6666_6666);
    exp_alu(4'd1, 32'h1111_1111, 1'b0, 1'b0, 32'd0, c + 2);
    src_q.push_back(1'b0);
    rdy("flush_c0", 1'b1, 1'b1);
    tick();
    put_alu(4'd2, 32'h2222_2222, 1'b1, 1'b0, 32'h80);
    put_ld(4'd7, 32'h7777_7777);
    rdy("flush_c1", 1'b1, 1'b1);
    tick();
    put_alu(4'd3, 32'h3333_3333, 1'b0, 1'b0, 32'd0);
    put_ld(4'd8, 32'h8888_8888);
    flush = 1'b1;
    rdy("flush_c2", 1'b0, 1'b0);
    tick();
    idle();
    chk("flush_wb_clear", {63'd0, wb_valid}, 64'd0);
    rdy("flush_after", 1'b1, 1'b1);
    tick();
    repeat (3) tick();
    c = cyc;
    put_alu(4'd9, 32'h9999_0000, 1'b1, 1'b0, 32'h200);
    exp_alu(4'd9, 32'h9999_0000, 1'b1, 1'b0, 32'h200, c + 2);
    src_q.push_back(1'b0);
    rdy("post_flush", 1'b1, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    chk_drained("flush");

    // Reset mid-stream: LD buffer full, ALU {12} pending; nothing more emerges
    c = cyc;
    put_alu(4'd10, 32'hAAAA_0010, 1'b0, 1'b0, 32'd0);
    put_ld(4'd13, 32'hBBBB_0013);
    exp_alu(4'd10, 32'hAAAA_0010, 1'b0, 1'b0, 32'd0, c + 2);
    src_q.push_back(1'b0);
    rdy("rst_c0", 1'b1, 1'b1);
    tick();
    put_alu(4'd11, 32'hAAAA_0011, 1'b1, 1'b1, 32'h300);
    put_ld(4'd14, 32'hBBBB_0014);
    exp_alu(4'd11, 32'hAAAA_0011, 1'b1, 1'b1, 32'h300, c + 3);
    src_q.push_back(1'b0);
    rdy("rst_c1", 1'b1, 1'b1);
    tick();
    put_alu(4'd12, 32'hAAAA_0012, 1'b0, 1'b0, 32'd0);
    ld_valid = 1'b0;
    rdy("rst_c2", 1'b1, 1'b0);
    tick();
    idle();
    rst_aL = 1'b0;
    tick();
    rst_aL = 1'b1;
    chk_wb_zero("midrst");
    rdy("midrst", 1'b1, 1'b1);
    tick();
    repeat (5) tick();
    chk_drained("midrst");
`endif

    // ALU request into an empty buffer: 1-cycle latency only with bypass
    c = cyc;
    put_alu(4'd4, 32'h4444_4444, 1'b1, 1'b0, 32'h444);
    exp_alu(4'd4, 32'h4444_4444, 1'b1, 1'b0, 32'h444, c + LAT);
    src_q.push_back(1'b0);
    rdy("latency", 1'b1, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    chk_drained("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
Arbiter that lets the ALU and the load unit share a single writeback/wakeup port into the ROB; that port is one write to the ROB entry RAM per cycle.
- Each requester gets a small FIFO buffer with a ready-then-valid handshake.
- Each cycle, one buffered head is granted and presented as a registered one-cycle writeback pulse.
- ALU has fixed priority, with a starvation counter that guarantees load progress.
- A retire-time redirect flushes all buffered writebacks.

Parameters:
ALU_BUF_DEPTH, 2, ALU buffer entries (>=1)
LD_BUF_DEPTH, 2, load buffer entries (>=1)
STARVE_LIMIT, 3, consecutive ALU wins over a waiting load before the load is forced (>=1)
ROB_ID_WIDTH, 4, ROB index width
REG_DATA_WIDTH, 32, register data width
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_aL  in  1  synchronous active-low reset, sampled on rising edge of clk
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU buffer can accept
alu_rob_id  in  ROB_ID_WIDTH  destination ROB entry
alu_reg_data  in  REG_DATA_WIDTH  result
alu_npc_valid  in  1  branch/jalr resolved next PC present
alu_npc_mispred  in  1  branch mispredicted
alu_npc  in  ADDR_WIDTH  resolved next PC
ld_valid  in  1  load writeback request
ld_ready  out  1  load buffer can accept
ld_rob_id  in  ROB_ID_WIDTH  destination ROB entry
ld_reg_data  in  REG_DATA_WIDTH  load data
flush  in  1  retire redirect; discard everything
wb_valid  out  1  writeback pulse to ROB (ROB always accepts)
wb_src  out  1  0 = ALU, 1 = load
wb_rob_id  out  ROB_ID_WIDTH  granted ROB entry
wb_reg_data  out  REG_DATA_WIDTH  granted data
wb_npc_valid  out  1  forced 0 when wb_src=1
wb_npc_mispred  out  1  forced 0 when wb_src=1
wb_npc  out  ADDR_WIDTH  forced 0 when wb_src=1

Behaviour:
- Reset (rst_aL=0 at an edge):
  - Both buffers empty; starve counter 0.
  - All wb_* outputs 0.
  - alu_ready and ld_ready read 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered entries without emitting them.
- Handshake:
  - x_ready = (occupancy != DEPTH) && !flush. Purely from registered occupancy and flush, never from x_valid.
  - Enqueue on a rising edge when x_valid && x_ready.
  - A full buffer never accepts, even if it is dequeued in the same cycle (no pass-through).
- Buffers:
  - Circular FIFOs with wrapping read/write pointers; occupancy counter of width $clog2(DEPTH+1).
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - Entry order within a requester is preserved.
- Grant (combinational from buffer heads; ALU head valid and LD head valid, evaluated in priority order):
  - Neither head valid: no grant.
  - Only one head valid: grant it.
  - Both valid and starve counter == STARVE_LIMIT: grant LD.
  - Both valid otherwise: grant ALU.
- Starve counter:
  - Increments when both heads are valid and ALU is granted; saturates at STARVE_LIMIT.
  - Clears when LD is granted or the LD buffer is empty.
- Output:
  - On a grant, the head is dequeued and the wb_* registers load it at that edge; wb_valid is 1 for exactly that following cycle.
  - With no grant, wb_valid=0 and data fields hold their last value. Data is only meaningful with wb_valid.
  - Latency: a request accepted at edge t produces wb_valid earliest in the cycle after edge t+1 (2 cycles from presentation).
  - Throughput: 1 writeback per cycle.
- Flush (sampled at an edge):
  - Empties both buffers, clears the starve counter, clears wb_valid for the next cycle, and drops any grant in that cycle.
  - Requests presented during the flush cycle are not accepted (ready=0).
  - Flush with rst_aL=0: reset wins (identical result).
- Duplicate or out-of-range ROB ids are not checked.

Optional Feature:
ROB_WB_ARB_BYPASS_EN
- Defined:
  - An input whose buffer is empty may compete for the grant in the same cycle it is presented, treated as that buffer's head.
  - If granted, it goes directly to the wb_* registers without enqueueing, giving 1-cycle latency.
  - If not granted, it enqueues normally.
  - Bypass is disabled during flush.
- Undefined: always 2-cycle minimum latency as above.

Test Plan:
- Reset then single ALU req (rob_id=5, data=0xDEADBEEF, npc_valid=1, mispred=1, npc=0x100) -> wb_valid one cycle, 2 cycles after presentation, wb_src=0, all fields matching.
- ALU and LD both presented every cycle for 12 cycles, STARVE_LIMIT=3 -> grant pattern A,A,A,L repeating; wb_npc_* = 0 on every L pulse.
- Fill ALU buffer (2 reqs, no grants possible: hold LD forced with ALU blocked by flush-free stall via continuous LD starvation test) then 3rd req -> alu_ready=0 until the first dequeue; order preserved (rob_ids 1,2,3 emerge in order).
- Buffers holding ALU {1,2} and LD {7}, assert flush one cycle -> ready=0 that cycle, no wb_valid afterwards, occupancy 0, next request is handled normally.
- rst_aL=0 for one edge mid-stream with full buffers -> all outputs 0 next cycle, nothing emitted later; with ROB_WB_ARB_BYPASS_EN, an ALU req into an empty buffer -> wb_valid in the very next cycle.
